// File: rtl/lamp_pkg.sv
// Shared constants, fault codes and state encoding for the lamp conflict monitor.
// Optional feature macro (see top): LAMP_MON_FAULT_COUNT_EN.
package lamp_pkg;

  localparam logic [2:0] LAMP_GREEN = 3'b001;
  localparam logic [2:0] LAMP_AMBER = 3'b010;
  localparam logic [2:0] LAMP_RED   = 3'b100;
  localparam logic [2:0] LAMP_DARK  = 3'b000;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_CONFLICT = 2'b01;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;
  localparam logic [1:0] FAULT_DARK     = 2'b11;

  typedef enum logic [1:0] {
    MONITOR     = 2'b00,
    FAULT_FLASH = 2'b01,
    RECOVER     = 2'b10
  } mon_state_t;

  // True when at least two bits of a 4-bit vector are set.
  function automatic logic two_or_more4(input logic [3:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[0] & v[3]) |
           (v[1] & v[2]) | (v[1] & v[3]) | (v[2] & v[3]);
  endfunction

endpackage

// File: rtl/lamp_persist_cnt.sv
// Saturating consecutive-cycle counter. 'hit' is asserted combinationally on
// the LIMIT-th consecutive cycle of 'cond' (and every cycle after it), so the
// consumer can act on the edge that ends that cycle.
module lamp_persist_cnt #(
  parameter int LIMIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic cond,
  output logic hit
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] SAT = CW'(LIMIT);
  localparam logic [CW-1:0] THR = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_r;

  // Count consecutive cycles of cond, saturating at LIMIT; any gap or clear restarts.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_r <= '0;
    end else if (!cond) begin
      cnt_r <= '0;
    end else if (cnt_r != SAT) begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign hit = cond && (cnt_r >= THR);

endmodule

// File: rtl/lamp_conflict_monitor.sv
// Safety stage between the signal sequencer and the lamp drivers. Passes head
// codes through with one cycle of latency, and on a debounced conflict, illegal
// code or dark timeout latches a fault and flashes all heads red until cleared.
// Optional macro LAMP_MON_FAULT_COUNT_EN adds a saturating fault_count output.
module lamp_conflict_monitor
  import lamp_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 3,
  parameter int DARK_MAX     = 8,
  parameter int FLASH_HALF   = 4,
  parameter int ALL_RED_CYC  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] n_in,
  input  logic [2:0] s_in,
  input  logic [2:0] e_in,
  input  logic [2:0] w_in,
  input  logic       clr_fault,
  output logic [2:0] n_out,
  output logic [2:0] s_out,
  output logic [2:0] e_out,
  output logic [2:0] w_out,
  output logic       fault,
  output logic [1:0] fault_code
`ifdef LAMP_MON_FAULT_COUNT_EN
  ,
  output logic [7:0] fault_count
`endif
);

  localparam int DW = $clog2(FLASH_HALF + 1);
  localparam int RW = $clog2(ALL_RED_CYC + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(FLASH_HALF - 1);
  localparam logic [RW-1:0] REC_LAST = RW'(ALL_RED_CYC - 1);

  mon_state_t    state_r, state_nxt_s;
  logic [DW-1:0] div_r, div_nxt_s;
  logic [RW-1:0] rec_r, rec_nxt_s;
  logic          phase_r, phase_nxt_s;
  logic [2:0]    n_nxt_s, s_nxt_s, e_nxt_s, w_nxt_s;
  logic          fault_nxt_s;
  logic [1:0]    code_nxt_s, code_s;

  logic          conflict_raw_s, illegal_raw_s, cnt_clr_s;
  logic          conflict_hit_s, illegal_hit_s, dark_any_hit_s;
  logic          trigger_s, raw_viol_s;
  logic [3:0]    dark_raw_s, dark_hit_s;

  assign conflict_raw_s = two_or_more4({n_in[0], s_in[0], e_in[0], w_in[0]});
  assign illegal_raw_s  = two_or_more4({1'b0, n_in}) | two_or_more4({1'b0, s_in}) |
                          two_or_more4({1'b0, e_in}) | two_or_more4({1'b0, w_in});
  assign dark_raw_s     = {n_in == LAMP_DARK, s_in == LAMP_DARK,
                           e_in == LAMP_DARK, w_in == LAMP_DARK};
  // Persistence history is discarded while recovering so MONITOR starts fresh.
  assign cnt_clr_s      = (state_r == RECOVER);

  lamp_persist_cnt #(.LIMIT(DEBOUNCE_CYC)) u_conflict_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr_s), .cond(conflict_raw_s), .hit(conflict_hit_s)
  );

  lamp_persist_cnt #(.LIMIT(DEBOUNCE_CYC)) u_illegal_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr_s), .cond(illegal_raw_s), .hit(illegal_hit_s)
  );

  for (genvar g = 0; g < 4; g++) begin : g_dark
    lamp_persist_cnt #(.LIMIT(DARK_MAX + 1)) u_dark_cnt (
      .clk(clk), .rst(rst), .clr(cnt_clr_s), .cond(dark_raw_s[g]), .hit(dark_hit_s[g])
    );
  end

  assign dark_any_hit_s = |dark_hit_s;
  assign trigger_s      = conflict_hit_s | illegal_hit_s | dark_any_hit_s;
  assign raw_viol_s     = conflict_raw_s | illegal_raw_s | dark_any_hit_s;
  assign code_s         = conflict_hit_s ? FAULT_CONFLICT :
                          illegal_hit_s  ? FAULT_ILLEGAL  :
                          dark_any_hit_s ? FAULT_DARK     : FAULT_NONE;

  // Next-state, next-output and flash/recover timing decisions.
  always_comb begin
    state_nxt_s = state_r;
    div_nxt_s   = div_r;
    rec_nxt_s   = rec_r;
    phase_nxt_s = phase_r;
    fault_nxt_s = fault;
    code_nxt_s  = fault_code;
    n_nxt_s     = LAMP_RED;
    s_nxt_s     = LAMP_RED;
    e_nxt_s     = LAMP_RED;
    w_nxt_s     = LAMP_RED;
    case (state_r)
      MONITOR: begin
        if (trigger_s) begin
          state_nxt_s = FAULT_FLASH;
          fault_nxt_s = 1'b1;
          code_nxt_s  = code_s;
          phase_nxt_s = 1'b1;
          div_nxt_s   = '0;
        end else begin
          n_nxt_s = n_in;
          s_nxt_s = s_in;
          e_nxt_s = e_in;
          w_nxt_s = w_in;
        end
      end
      FAULT_FLASH: begin
        if (clr_fault && !raw_viol_s) begin
          state_nxt_s = RECOVER;
          rec_nxt_s   = '0;
          phase_nxt_s = 1'b1;
          div_nxt_s   = '0;
        end else begin
          if (div_r == DIV_LAST) begin
            div_nxt_s   = '0;
            phase_nxt_s = ~phase_r;
          end else begin
            div_nxt_s   = div_r + {{(DW-1){1'b0}}, 1'b1};
          end
          n_nxt_s = phase_nxt_s ? LAMP_RED : LAMP_DARK;
          s_nxt_s = phase_nxt_s ? LAMP_RED : LAMP_DARK;
          e_nxt_s = phase_nxt_s ? LAMP_RED : LAMP_DARK;
          w_nxt_s = phase_nxt_s ? LAMP_RED : LAMP_DARK;
        end
      end
      RECOVER: begin
        if (rec_r == REC_LAST) begin
          state_nxt_s = MONITOR;
          rec_nxt_s   = '0;
          fault_nxt_s = 1'b0;
          code_nxt_s  = FAULT_NONE;
        end else begin
          rec_nxt_s   = rec_r + {{(RW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nxt_s = RECOVER;
        rec_nxt_s   = '0;
      end
    endcase
  end

  // State, timers and registered lamp/fault outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= RECOVER;
      div_r      <= '0;
      rec_r      <= '0;
      phase_r    <= 1'b1;
      n_out      <= LAMP_RED;
      s_out      <= LAMP_RED;
      e_out      <= LAMP_RED;
      w_out      <= LAMP_RED;
      fault      <= 1'b0;
      fault_code <= FAULT_NONE;
    end else begin
      state_r    <= state_nxt_s;
      div_r      <= div_nxt_s;
      rec_r      <= rec_nxt_s;
      phase_r    <= phase_nxt_s;
      n_out      <= n_nxt_s;
      s_out      <= s_nxt_s;
      e_out      <= e_nxt_s;
      w_out      <= w_nxt_s;
      fault      <= fault_nxt_s;
      fault_code <= code_nxt_s;
    end
  end

`ifdef LAMP_MON_FAULT_COUNT_EN
  logic fault_entry_s;
  assign fault_entry_s = (state_r == MONITOR) && trigger_s;

  // Saturating count of fault entries; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_count <= 8'd0;
    end else if (fault_entry_s && (fault_count != 8'hFF)) begin
      fault_count <= fault_count + 8'd1;
    end else begin
      fault_count <= fault_count;
    end
  end
`endif

endmodule

// File: tb/tb_lamp_conflict_monitor.sv
// Self-checking bench for lamp_conflict_monitor: directed scenarios followed by
// random traffic, all checked every cycle against a behavioural model.
module tb_lamp_conflict_monitor;

  localparam int DEB = 3;
  localparam int DMAX = 8;
  localparam int FH = 4;
  localparam int ARC = 6;
  localparam int M_MON = 0;
  localparam int M_FLASH = 1;
  localparam int M_REC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr_fault = 1'b0;
  logic [2:0] n_in = 3'b100, s_in = 3'b100, e_in = 3'b100, w_in = 3'b100;
  logic [2:0] n_out, s_out, e_out, w_out;
  logic       fault;
  logic [1:0] fault_code;
`ifdef LAMP_MON_FAULT_COUNT_EN
  logic [7:0] fault_count;
`endif

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int         m_mode;
  int         m_run_conf, m_run_ill;
  int         m_run_dark[4];
  int         m_flash_t, m_rec_t;
  logic [2:0] m_out[4];
  logic       m_fault;
  logic [1:0] m_code;
  int         m_fcount;

  lamp_conflict_monitor #(
    .DEBOUNCE_CYC(DEB), .DARK_MAX(DMAX), .FLASH_HALF(FH), .ALL_RED_CYC(ARC)
  ) dut (
    .clk(clk), .rst(rst), .n_in(n_in), .s_in(s_in), .e_in(e_in), .w_in(w_in),
    .clr_fault(clr_fault), .n_out(n_out), .s_out(s_out), .e_out(e_out), .w_out(w_out),
    .fault(fault), .fault_code(fault_code)
`ifdef LAMP_MON_FAULT_COUNT_EN
    , .fault_count(fault_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge given this cycle's inputs.
  task automatic model_step(input logic r, input logic [2:0] n, s, e, w, input logic c);
    logic [2:0] h[4];
    int  greens;
    bit  conf, ill, conf_hit, ill_hit, dark_hit;
    h = '{n, s, e, w};
    if (r) begin
      m_mode = M_REC; m_rec_t = 0; m_flash_t = 0;
      m_run_conf = 0; m_run_ill = 0;
      for (int i = 0; i < 4; i++) begin m_run_dark[i] = 0; m_out[i] = 3'b100; end
      m_fault = 1'b0; m_code = 2'b00; m_fcount = 0;
      return;
    end
    greens = 0; ill = 0;
    for (int i = 0; i < 4; i++) begin
      greens += int'(h[i][0]);
      if ($countones(h[i]) >= 2) ill = 1;
    end
    conf = (greens >= 2);
    if (m_mode == M_REC) begin
      m_run_conf = 0; m_run_ill = 0;
      for (int i = 0; i < 4; i++) m_run_dark[i] = 0;
    end else begin
      m_run_conf = conf ? m_run_conf + 1 : 0;
      m_run_ill  = ill  ? m_run_ill + 1  : 0;
      for (int i = 0; i < 4; i++) m_run_dark[i] = (h[i] == 3'b000) ? m_run_dark[i] + 1 : 0;
    end
    conf_hit = (m_run_conf >= DEB);
    ill_hit  = (m_run_ill >= DEB);
    dark_hit = 0;
    for (int i = 0; i < 4; i++) if (m_run_dark[i] >= DMAX + 1) dark_hit = 1;
    if (m_mode == M_MON) begin
      if (conf_hit || ill_hit || dark_hit) begin
        m_mode = M_FLASH; m_flash_t = 0; m_fault = 1'b1;
        m_code = conf_hit ? 2'b01 : (ill_hit ? 2'b10 : 2'b11);
        for (int i = 0; i < 4; i++) m_out[i] = 3'b100;
        if (m_fcount < 255) m_fcount++;
      end else begin
        for (int i = 0; i < 4; i++) m_out[i] = h[i];
      end
    end else if (m_mode == M_FLASH) begin
      if (c && !(conf || ill || dark_hit)) begin
        m_mode = M_REC; m_rec_t = 0;
        for (int i = 0; i < 4; i++) m_out[i] = 3'b100;
      end else begin
        m_flash_t++;
        for (int i = 0; i < 4; i++) m_out[i] = (((m_flash_t / FH) % 2) == 0) ? 3'b100 : 3'b000;
      end
    end else begin
      for (int i = 0; i < 4; i++) m_out[i] = 3'b100;
      m_rec_t++;
      if (m_rec_t == ARC) begin
        m_mode = M_MON; m_rec_t = 0; m_fault = 1'b0; m_code = 2'b00;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input string tag, input logic r, input logic [2:0] n, s, e, w,
                      input logic c);
    @(negedge clk);
    rst = r; n_in = n; s_in = s; e_in = e; w_in = w; clr_fault = c;
    model_step(r, n, s, e, w, c);
    @(posedge clk);
    #1;
    chk({tag, ".n_out"}, {5'd0, n_out}, {5'd0, m_out[0]});
    chk({tag, ".s_out"}, {5'd0, s_out}, {5'd0, m_out[1]});
    chk({tag, ".e_out"}, {5'd0, e_out}, {5'd0, m_out[2]});
    chk({tag, ".w_out"}, {5'd0, w_out}, {5'd0, m_out[3]});
    chk({tag, ".fault"}, {7'd0, fault}, {7'd0, m_fault});
    chk({tag, ".fault_code"}, {6'd0, fault_code}, {6'd0, m_code});
`ifdef LAMP_MON_FAULT_COUNT_EN
    chk({tag, ".fault_count"}, fault_count, m_fcount[7:0]);
`endif
  endtask

  // Legal pattern: south green, everyone else red.
  task automatic legal(input string tag, input int cycles, input logic c);
    for (int i = 0; i < cycles; i++) step(tag, 1'b0, 3'b100, 3'b001, 3'b100, 3'b100, c);
  endtask

  initial begin
    logic [2:0] rh[4];
    int         gi;

    // reset with legal inputs, then the all-red recover window and pass-through
    step("reset", 1'b1, 3'b100, 3'b001, 3'b100, 3'b100, 1'b0);
    step("reset", 1'b1, 3'b100, 3'b001, 3'b100, 3'b100, 1'b0);
    legal("recover_after_reset", 10, 1'b0);
    chk("pass_through_s", {5'd0, s_out}, 8'd1);

    // two-cycle conflict glitch must not fault
    for (int i = 0; i < 2; i++) step("glitch", 1'b0, 3'b100, 3'b001, 3'b100, 3'b001, 1'b0);
    legal("after_glitch", 3, 1'b0);
    chk("glitch_no_fault", {7'd0, fault}, 8'd0);

    // three-cycle conflict latches code 01 and flashes
    for (int i = 0; i < 3; i++) step("conflict", 1'b0, 3'b100, 3'b001, 3'b100, 3'b001, 1'b0);
    chk("conflict_code", {6'd0, fault_code}, 8'd1);
    legal("flash", 12, 1'b0);

    // clear during an ongoing conflict is ignored, then a clean clear recovers
    step("clr_ignored", 1'b0, 3'b100, 3'b001, 3'b100, 3'b001, 1'b1);
    chk("clr_ignored_fault", {7'd0, fault}, 8'd1);
    legal("clr_ok", 1, 1'b1);
    legal("recover_after_clr", 9, 1'b0);
    chk("clr_fault_cleared", {7'd0, fault}, 8'd0);

    // illegal code together with a green conflict: conflict wins
    for (int i = 0; i < 3; i++) step("prio", 1'b0, 3'b011, 3'b100, 3'b001, 3'b001, 1'b0);
    chk("prio_code", {6'd0, fault_code}, 8'd1);
    legal("prio_flash", 3, 1'b0);
    legal("prio_clr", 1, 1'b1);
    legal("prio_recover", 8, 1'b0);

    // dark for DMAX cycles is tolerated, DMAX+1 is a fault
    for (int i = 0; i < DMAX; i++) step("dark_ok", 1'b0, 3'b100, 3'b001, 3'b100, 3'b000, 1'b0);
    step("dark_end", 1'b0, 3'b100, 3'b001, 3'b100, 3'b010, 1'b0);
    chk("dark_ok_no_fault", {7'd0, fault}, 8'd0);
    for (int i = 0; i < DMAX + 1; i++) step("dark_to", 1'b0, 3'b100, 3'b001, 3'b100, 3'b000, 1'b0);
    chk("dark_code", {6'd0, fault_code}, 8'd3);
    step("dark_clr_ignored", 1'b0, 3'b100, 3'b001, 3'b100, 3'b000, 1'b1);
    legal("dark_flash", 5, 1'b0);

    // reset mid-flash restarts the recover sequence
    step("rst_mid_flash", 1'b1, 3'b100, 3'b001, 3'b100, 3'b100, 1'b1);
    chk("rst_fault", {7'd0, fault}, 8'd0);
    legal("rst_recover", 9, 1'b0);

    // two faults for the optional counter
    for (int i = 0; i < 3; i++) step("cnt_f1", 1'b0, 3'b001, 3'b001, 3'b100, 3'b100, 1'b0);
    legal("cnt_clr1", 1, 1'b1);
    legal("cnt_rec1", 7, 1'b0);
    for (int i = 0; i < 3; i++) step("cnt_f2", 1'b0, 3'b110, 3'b001, 3'b100, 3'b100, 1'b0);
    chk("ill_code", {6'd0, fault_code}, 8'd2);
`ifdef LAMP_MON_FAULT_COUNT_EN
    chk("fault_count_two", fault_count, 8'd2);
`endif
    legal("cnt_clr2", 1, 1'b1);
    legal("cnt_rec2", 7, 1'b0);

    // random traffic with sticky inputs, occasional corruption, clears and resets
    rh = '{3'b100, 3'b001, 3'b100, 3'b100};
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(0, 9) < 3) begin
        gi = $urandom_range(0, 3);
        for (int i = 0; i < 4; i++) begin
          if (i == gi) rh[i] = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b010;
          else rh[i] = ($urandom_range(0, 5) == 0) ? 3'b000 : 3'b100;
        end
        if ($urandom_range(0, 7) == 0) rh[$urandom_range(0, 3)] = 3'($urandom_range(0, 7));
      end
      step("random", ($urandom_range(0, 299) == 0), rh[0], rh[1], rh[2], rh[3],
           ($urandom_range(0, 5) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lamp_conflict_monitor.md
Name: lamp_conflict_monitor

Overview:
- Downstream safety stage between the traffic-light sequencer and the lamp drivers.
- Registers the four 3-bit head codes (N/S/E/W) and checks them every cycle for conflicting greens, illegal codes and excessive dark time.
- In normal operation it passes the codes through with one cycle of latency.
- On a debounced violation it latches a fault and forces all heads to flashing red until the fault is cleared.

Parameters:
- DEBOUNCE_CYC, 3: consecutive cycles a conflict or illegal condition must persist before the fault latches (min 1).
- DARK_MAX, 8: maximum consecutive cycles any single head may read 3'b000 (amber blink gap). Dark for DARK_MAX+1 cycles is a fault.
- FLASH_HALF, 4: cycles per half-period of the red flash in fault mode.
- ALL_RED_CYC, 6: cycles of solid all-red after reset and after a fault clear.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- n_in  in  3  north head code from sequencer
- s_in  in  3  south head code
- e_in  in  3  east head code
- w_in  in  3  west head code
- clr_fault  in  1  single-cycle fault-clear request
- n_out  out  3  north lamp drive
- s_out  out  3  south lamp drive
- e_out  out  3  east lamp drive
- w_out  out  3  west lamp drive
- fault  out  1  latched fault flag
- fault_code  out  2  00 none, 01 green conflict, 10 illegal code, 11 dark timeout

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Lamp encoding: bit0 green, bit1 amber, bit2 red. Legal codes are 001, 010, 100 and 000 (dark).
- Reset values: all *_out = 3'b100, fault = 0, fault_code = 00, all counters = 0, state = RECOVER.
- Raw conditions, evaluated combinationally on *_in each cycle:
  - conflict: green bit set on 2 or more heads. Green plus amber on another head is legal.
  - illegal: any head has 2 or more bits set.
  - dark: any head = 000. A per-head dark counter counts consecutive cycles and resets when that head is non-zero.
- Persistence: each condition has its own consecutive-cycle counter, saturating at its threshold and reset to 0 on any cycle the condition is absent.
- States:
  - MONITOR:
    - *_out <= *_in (1-cycle latency).
    - If a violation is present in cycles k..k+DEBOUNCE_CYC-1, then at the edge ending cycle k+DEBOUNCE_CYC-1: fault <= 1, fault_code <= code, state <= FAULT_FLASH, flash phase <= on. The outputs are therefore red from cycle k+DEBOUNCE_CYC onward.
    - Dark timeout uses the same trigger at DARK_MAX+1 consecutive dark cycles on one head.
  - FAULT_FLASH:
    - All *_out = 3'b100 in the on phase and 3'b000 in the off phase; the phase toggles every FLASH_HALF cycles, with the divider wrapping at FLASH_HALF-1.
    - Inputs are still evaluated, but fault_code is frozen at the first fault.
    - clr_fault is accepted only if no raw condition (conflict, illegal, dark>DARK_MAX) is present that cycle. On acceptance, state <= RECOVER.
    - If clr_fault coincides with a raw violation, it is ignored and the state stays FAULT_FLASH.
  - RECOVER:
    - All *_out = 3'b100 for ALL_RED_CYC cycles, then MONITOR; fault and fault_code clear on that transition.
    - Persistence counters are held at 0 in RECOVER.
- Priority when several conditions trigger on the same cycle: conflict > illegal > dark.
- rst at any time: immediate return to reset values and RECOVER. Reset overrides clr_fault.
- clr_fault in MONITOR or RECOVER: no effect.

Optional Feature:
- Macro: LAMP_MON_FAULT_COUNT_EN
- Defined: adds output fault_count[7:0], reset to 0, incremented on every MONITOR->FAULT_FLASH transition, saturating at 255, cleared only by rst.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package lamp_pkg holds:
  - LAMP_GREEN/AMBER/RED/DARK constants;
  - FAULT_NONE/CONFLICT/ILLEGAL/DARK codes;
  - the state encoding (MONITOR, FAULT_FLASH, RECOVER).
- Sub-module lamp_persist_cnt (parameter LIMIT; inputs clk, rst, clr, cond; output hit): a saturating consecutive-cycle counter.
  - Instantiated once for conflict, once for illegal, and four times for dark (one per head).

Test Plan:
- Reset release with legal inputs (S=001, others 100): outputs all 100 for 6 cycles, then S_out=001 one cycle after input; fault=0.
- S=001 and W=001 held 3 cycles: fault=1, code=01, outputs 100/000 toggling every 4 cycles. A 2-cycle glitch produces no fault.
- N=011 held 3 cycles together with an E/W green conflict on the same cycles: code=01 (priority).
- W=000 held 8 cycles then 010: no fault. W=000 held 9 cycles: code=11.
- In FAULT_FLASH, clr_fault with inputs still conflicting: ignored. clr_fault with legal inputs: 6 cycles all-red, then pass-through and fault=0.
- rst asserted mid-flash: next cycle outputs 100, fault=0, RECOVER sequence restarts. With LAMP_MON_FAULT_COUNT_EN defined, 2 faults give fault_count=2.
